// File: rtl/psram_arbiter.sv
// Two-port round-robin arbiter in front of one PsramController command port.
// Keeps one transaction in flight, bounds each one with a timeout, and returns
// a per-port ack, an error flag and the captured read data.
module psram_arbiter #(
  parameter int unsigned TIMEOUT   = 32,   // max WAIT cycles before abort (<= 255)
  parameter bit          INIT_WAIT = 1'b1  // hold grants until controller busy first drops
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_byte_we,
  input  logic [21:0] p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_byte_we,
  input  logic [21:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [15:0] p1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_byte_write,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_busy,
  output logic        grant
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam state_t     RESET_STATE = INIT_WAIT ? S_INIT : S_IDLE;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic       last;       // port served by the previous transaction
  logic       we;         // direction of the transaction in flight
  logic       err;        // outcome of the transaction in flight
  logic [7:0] wcnt;       // cycles spent in WAIT, saturating
  logic       take;       // a grant is made this cycle
  logic       pick;       // port chosen when take is high
  logic       done_ok;    // controller finished
  logic       done_to;    // transaction timed out

  // State register; an asserted reset aborts any transaction immediately.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_next;
  end

  // Next-state decode, grant choice and the one-cycle strobes.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    pick       = grant;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    p0_ack     = 1'b0;
    p1_ack     = 1'b0;
    p0_err     = 1'b0;
    p1_err     = 1'b0;
    unique case (state)
      S_INIT: begin
        if (!mem_busy) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (p0_req && p1_req) begin
          take = 1'b1;
          pick = ~last;
        end else if (p0_req || p1_req) begin
          take = 1'b1;
          pick = p1_req;
        end
        if (take) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        mem_write  = we;
        mem_read   = ~we;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // Busy is only raised the cycle after the pulse, so ignore it at wcnt 0.
        done_ok = (wcnt != 8'd0) && !mem_busy;
        done_to = (wcnt == TIMEOUT_CNT);
        if (done_ok || done_to) state_next = S_DONE;
      end
      S_DONE: begin
        p0_ack     = ~grant;
        p1_ack     = grant;
        p0_err     = ~grant & err;
        p1_err     = grant & err;
        state_next = S_IDLE;
      end
      default: state_next = RESET_STATE;
    endcase
  end

  // Command latch, wait counter, completion status, read data and fairness.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant          <= 1'b0;
      last           <= 1'b1;
      we             <= 1'b0;
      err            <= 1'b0;
      wcnt           <= 8'd0;
      mem_byte_write <= 1'b0;
      mem_addr       <= '0;
      mem_din        <= '0;
      p0_rdata       <= '0;
      p1_rdata       <= '0;
    end else begin
      if (take) begin
        grant          <= pick;
        we             <= pick ? p1_we      : p0_we;
        mem_byte_write <= pick ? p1_byte_we : p0_byte_we;
        mem_addr       <= pick ? p1_addr    : p0_addr;
        mem_din        <= pick ? p1_wdata   : p0_wdata;
      end
      if (state == S_ISSUE)                         wcnt <= 8'd0;
      else if (state == S_WAIT && wcnt != 8'hFF)    wcnt <= wcnt + 8'd1;
      if (done_ok || done_to) begin
        // Completion takes priority over a coincident timeout.
        err <= ~done_ok;
        if (done_ok && !we) begin
          if (grant) p1_rdata <= mem_dout;
          else       p0_rdata <= mem_dout;
        end
      end
      if (state == S_DONE) last <= grant;
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a small busy-pulse controller model.
module tb_psram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p0_byte_we;
  logic [21:0] p0_addr;
  logic [15:0] p0_wdata;
  logic        p0_ack, p0_err;
  logic [15:0] p0_rdata;
  logic        p1_req, p1_we, p1_byte_we;
  logic [21:0] p1_addr;
  logic [15:0] p1_wdata;
  logic        p1_ack, p1_err;
  logic [15:0] p1_rdata;
  logic        mem_read, mem_write, mem_byte_write;
  logic [21:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_busy;
  logic        grant;

  int checks   = 0;
  int failures = 0;

  // Controller model: busy for busy_len cycles starting the cycle after a pulse.
  logic force_busy;
  int   busy_len;
  int   busy_cnt;

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset)                       busy_cnt <= 0;
    else if (mem_read || mem_write)  busy_cnt <= busy_len;
    else if (busy_cnt != 0)          busy_cnt <= busy_cnt - 1;
  end

  assign mem_busy = force_busy | (busy_cnt != 0);

  psram_arbiter #(.TIMEOUT(32), .INIT_WAIT(1'b1)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_byte_we(p0_byte_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_byte_we(p1_byte_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_write(mem_byte_write),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy),
    .grant(grant)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ports"}, {28'd0, p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata}, 64'd0);
    check({tag, "_mem"}, {23'd0, mem_read, mem_write, mem_byte_write, mem_addr, mem_din, grant}, 64'd0);
  endtask

  // Ticks until the given port acks; returns ticks taken (999 if none) and
  // the number of extra command pulses seen meanwhile.
  task automatic wait_ack(input bit port, input int max_ticks, output int n, output int pulses);
    n = 999;
    pulses = 0;
    for (int i = 1; i <= max_ticks; i++) begin
      tick();
      if (mem_read || mem_write) pulses++;
      if (port ? p1_ack : p0_ack) begin
        n = i;
        break;
      end
    end
  endtask

  // One transaction from IDLE with no other requester; ends back in IDLE.
  task automatic do_txn(input string tag, input bit port, input bit we, input bit bwe,
                        input logic [21:0] addr, input logic [15:0] wdata,
                        input logic [15:0] dout, input int blen,
                        input int exp_lat, input bit exp_err);
    int n, pulses;
    busy_len = blen;
    mem_dout = dout;
    if (port) begin
      p1_we = we; p1_byte_we = bwe; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_byte_we = bwe; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end
    tick();
    check({tag, "_pulse"}, {62'd0, mem_write, mem_read}, we ? 64'd2 : 64'd1);
    check({tag, "_addr_grant"}, {41'd0, mem_addr, grant}, {41'd0, addr, port});
    if (we) check({tag, "_din_bwe"}, {47'd0, mem_din, mem_byte_write}, {47'd0, wdata, bwe});
    wait_ack(port, 60, n, pulses);
    check({tag, "_ack_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_err"}, {63'd0, port ? p1_err : p0_err}, {63'd0, exp_err});
    check({tag, "_extra_pulses"}, 64'(pulses), 64'd0);
    if (!we && !exp_err) check({tag, "_rdata"}, {48'd0, port ? p1_rdata : p0_rdata}, {48'd0, dout});
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pulses, acks;

    // 1: reset, controller busy for 100 cycles, p0 requesting meanwhile.
    reset = 1'b1; force_busy = 1'b1; busy_len = 0; mem_dout = 16'h0000;
    p0_req = 1'b0; p0_we = 1'b0; p0_byte_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_byte_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    tick(); tick();
    check_all_zero("reset");
    p0_we = 1'b1; p0_byte_we = 1'b1; p0_addr = 22'h000123; p0_wdata = 16'hC3C3;
    p0_req = 1'b1; busy_len = 6;
    reset = 1'b0;
    pulses = 0; acks = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (mem_read || mem_write) pulses++;
      if (p0_ack || p1_ack) acks++;
    end
    check("init_no_pulse", 64'(pulses), 64'd0);
    check("init_no_ack", 64'(acks), 64'd0);
    force_busy = 1'b0;
    tick();
    check("init_drop_plus1", {62'd0, mem_write, mem_read}, 64'd0);
    tick();
    // 2: the held p0 write goes out exactly two cycles after busy drops.
    check("t2_pulse", {62'd0, mem_write, mem_read}, 64'd2);
    check("t2_cmd", {23'd0, mem_byte_write, mem_addr, mem_din, grant},
          {23'd0, 1'b1, 22'h000123, 16'hC3C3, 1'b0});
    wait_ack(1'b0, 40, n, pulses);
    check("t2_ack_latency", 64'(n), 64'd8);
    check("t2_err", {63'd0, p0_err}, 64'd0);
    check("t2_extra_pulses", 64'(pulses), 64'd0);
    p0_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (p0_ack) acks++;
    end
    check("t2_single_ack", 64'(acks), 64'd0);
    check("t2_addr_stable", {42'd0, mem_addr}, {42'd0, 22'h000123});

    // 3: p0 read first, then p1 read; p0 data must survive p1's read.
    do_txn("t3_p0_read", 1'b0, 1'b0, 1'b0, 22'h000010, 16'h0000, 16'h1111, 1, 3, 1'b0);
    do_txn("t3_p1_read", 1'b1, 1'b0, 1'b0, 22'h0FFFFF, 16'h0000, 16'h5A3C, 3, 5, 1'b0);
    check("t3_p0_rdata_kept", {48'd0, p0_rdata}, {48'd0, 16'h1111});
    mem_dout = 16'hFFFF;
    tick(); tick();
    check("t3_p1_rdata_held", {48'd0, p1_rdata}, {48'd0, 16'h5A3C});

    // 4: from reset, both ports request continuously.
    reset = 1'b1;
    tick();
    reset = 1'b0; busy_len = 2; mem_dout = 16'h7777;
    p0_we = 1'b1; p0_byte_we = 1'b0; p0_addr = 22'h0000A0; p0_wdata = 16'h00A0;
    p1_we = 1'b0; p1_byte_we = 1'b0; p1_addr = 22'h0000A1;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int t = 0; t < 8; t++) begin
      n = 999;
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (mem_read || mem_write) begin
          n = i;
          break;
        end
      end
      check($sformatf("t4_pulse_found_%0d", t), 64'(n < 999), 64'd1);
      check($sformatf("t4_grant_%0d", t), {41'd0, mem_addr, grant},
            (t % 2 == 1) ? {41'd0, 22'h0000A1, 1'b1} : {41'd0, 22'h0000A0, 1'b0});
      check($sformatf("t4_dir_%0d", t), {62'd0, mem_write, mem_read},
            (t % 2 == 1) ? 64'd1 : 64'd2);
      wait_ack((t % 2 == 1), 20, n, pulses);
      check($sformatf("t4_ack_%0d", t), {62'd0, p1_ack, p0_ack},
            (t % 2 == 1) ? 64'd2 : 64'd1);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    tick();

    // 5: timeout with busy stuck high; p0 read data must not be overwritten.
    do_txn("t5_p0_read", 1'b0, 1'b0, 1'b0, 22'h000020, 16'h0000, 16'h2222, 1, 3, 1'b0);
    force_busy = 1'b1;
    do_txn("t5_timeout", 1'b0, 1'b0, 1'b0, 22'h000030, 16'h0000, 16'hBEEF, 0, 34, 1'b1);
    check("t5_rdata_kept", {48'd0, p0_rdata}, {48'd0, 16'h2222});
    force_busy = 1'b0;
    do_txn("t5_p1_after", 1'b1, 1'b1, 1'b0, 22'h000040, 16'h4444, 16'h0000, 2, 4, 1'b0);

    // 6: reset in WAIT clears outputs at once and re-enters INIT.
    busy_len = 10;
    p0_we = 1'b1; p0_byte_we = 1'b0; p0_addr = 22'h000003; p0_wdata = 16'h1234;
    p0_req = 1'b1;
    tick();
    check("t6_pulse", {62'd0, mem_write, mem_read}, 64'd2);
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1 check_all_zero("t6_async");
    force_busy = 1'b1;
    tick(); tick();
    reset = 1'b0;
    pulses = 0; acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_read || mem_write) pulses++;
      if (p0_ack || p1_ack) acks++;
    end
    check("t6_init_no_pulse", 64'(pulses), 64'd0);
    check("t6_no_ack", 64'(acks), 64'd0);
    force_busy = 1'b0;
    tick();
    check("t6_drop_plus1", {62'd0, mem_write, mem_read}, 64'd0);
    tick();
    check("t6_reissue", {62'd0, mem_write, mem_read}, 64'd2);
    wait_ack(1'b0, 30, n, pulses);
    check("t6_ack_latency", 64'(n), 64'd12);
    p0_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
